posit_accum_feeder: RTL
=======================

# posit_accum_feeder

Upstream sequencer for the posit accumulator (`positaccum_*`). It buffers a valid/ready stream of 32-bit posit vectors delimited by `in_last` and issues one element per accumulator round-trip, so every addition sees the previous partial sum. It clears the accumulator's feedback loop between vectors and returns one final sum per vector on a valid/ready output.

## Interface
- `LAT`, 16: accumulator round-trip latency in cycles, from `acc_in` sampling to `acc_result` reflecting that element; ≥4.
- `DEPTH`, 16: input FIFO depth, power of two; entries are {last, data[31:0]}.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `in_data` in 32: posit element.
- `in_last` in 1: marks the final element of a vector.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `acc_in` out 32: element to the accumulator `in1`.
- `acc_start` out 1: to the accumulator `start`.
- `acc_clr` out 1: ORed with `rst` at the accumulator's reset pin.
- `acc_result` in 32, `acc_inf` in 1, `acc_zero` in 1: accumulator outputs.
- `out_sum` out 32, `out_inf` out 1, `out_zero` out 1: captured vector sum.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FIFO write on `in_valid & in_ready`. `in_ready = ~full`, forced 0 while `rst` is high. FIFO read only in ISSUE.
- States: CLEAR, IDLE, PRIME, ISSUE, SPACE, DRAIN, OUT.
- CLEAR: `acc_clr`=1 for exactly LAT cycles, which flushes stale partial sums out of the feedback loop. Then go to IDLE.
- IDLE: when the FIFO is non-empty, go to PRIME.
- PRIME: `acc_start`=1 for one cycle. The accumulator gates `in1` with the previous cycle's start. Go to ISSUE.
- ISSUE (1 cycle):
  - Pop the FIFO head and drive `acc_in` = head data.
  - If the head has last=1, go to DRAIN. Otherwise go to SPACE.
- SPACE: wait until LAT cycles have elapsed since the ISSUE cycle.
  - Then, if the FIFO is non-empty, go to ISSUE. Otherwise stay in SPACE, holding `acc_start`=1 and `acc_in`=0.
  - Adding zero is harmless.
- DRAIN: hold `acc_start`=1 and `acc_in`=0 for LAT cycles. Then capture `acc_result`/`acc_inf`/`acc_zero` into the output registers and go to OUT.
- OUT: `out_valid`=1 with the output registers stable. When `out_valid & out_ready`, go to CLEAR.
- Outside ISSUE, `acc_in`=0. `acc_start`=1 in PRIME, ISSUE, SPACE and DRAIN, and 0 otherwise.
- A single cycle counter (`$clog2(LAT)+1` bits) serves CLEAR, SPACE and DRAIN. It resets to 0 on every state entry.
- Inf/zero pass through unmodified. No arithmetic is done on posit data.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=CLEAR, counter=0, FIFO empty.
  - `acc_clr`=1, `acc_in`=0, `acc_start`=0.
  - `out_valid`=0, `out_sum`=0, `out_inf`=0, `out_zero`=0.
  - `busy`=1, `in_ready`=0.
- After `rst` falls: CLEAR runs its full LAT cycles. `in_ready`=1 from the first cycle after deassertion, so input can be buffered during CLEAR.
- Issue spacing is exactly LAT cycles between consecutive ISSUE cycles when the FIFO never underflows.
- Vector latency for an N-element vector with data already buffered, counted from leaving IDLE to `out_valid`: 1 (PRIME) + 1 + (N-1)·LAT + LAT cycles.
- FIFO full: `in_ready`=0, and no write occurs that cycle.
- Simultaneous FIFO read and write while full: the write is still refused. `in_ready` is computed from the pre-read full flag.
- Pointer wrap-around is mod DEPTH. Full/empty is distinguished by an extra pointer bit.
- An `in_last` vector of length 1 is legal: PRIME, then ISSUE, then DRAIN.
- `out_ready` held low: stay in OUT indefinitely with outputs stable. The FIFO keeps accepting data until full.
- Reset mid-vector: the whole state is discarded, including FIFO contents and the partial sum. No output is produced for that vector.

## Test plan
- ES=2, vector {0x40000000, 0x40000000 last} (1.0+1.0):
  - Required: `out_sum`=0x48000000 exactly 2+2·LAT cycles after leaving IDLE; `out_zero`=0, `out_inf`=0.
- Two back-to-back vectors {1.0,1.0,1.0 last} and {1.0 last}:
  - Required: 0x4C000000, then 0x40000000.
  - Required: LAT `acc_clr` cycles between them, proving no carry-over.
- Vector {1.0, -1.0 (0xC0000000) last}:
  - Required: `out_sum`=0x00000000 and `out_zero`=1.
- Underflow: feed element 2 only 3·LAT cycles after element 1.
  - Required: SPACE holds, `acc_in`=0 and `acc_start`=1 meanwhile, and the sum is still correct.
- Backpressure: DEPTH+4 writes with `out_ready`=0.
  - Required: `in_ready` drops after DEPTH accepted entries, no data is lost, and `out_sum` stays stable until `out_ready`.
- Assert `rst` mid-SPACE, then send {1.0 last}:
  - Required: all outputs return immediately to their reset values, and the result is 0x40000000 with no residue from the aborted vector.

Source files
------------

// File: rtl/posit_accum_feeder.sv
// Feeds one buffered posit element per accumulator round-trip,
// clears the feedback loop between vectors and returns each vector sum.
module posit_accum_feeder #(
  parameter int LAT   = 16,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] acc_in,
  output logic        acc_start,
  output logic        acc_clr,
  input  logic [31:0] acc_result,
  input  logic        acc_inf,
  input  logic        acc_zero,
  output logic [31:0] out_sum,
  output logic        out_inf,
  output logic        out_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT) + 1;

  localparam logic [2:0] CLEAR = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] PRIME = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] SPACE = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;
  localparam logic [2:0] OUT   = 3'd6;

  localparam logic [CW-1:0] C_LAST = CW'(LAT - 1);
  localparam logic [CW-1:0] C_SPC  = CW'(LAT - 2);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW:0]   P_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   P_WRAP = {1'b1, {AW{1'b0}}};

  logic [32:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic [32:0]   head;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          space_done;

  // Extra pointer bit tells a full FIFO from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == P_WRAP);

  assign in_ready = ~full & ~rst;
  assign wr_en    = in_valid & in_ready;
  assign rd_en    = (state == ISSUE) & ~empty;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + P_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + P_ONE;
      end
    end
  end

  // Next ISSUE must land LAT cycles after the previous one.
  assign space_done = (cnt >= C_SPC);

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (cnt == C_LAST) state_nxt = IDLE;
      IDLE:  if (!empty) state_nxt = PRIME;
      PRIME: state_nxt = ISSUE;
      ISSUE: state_nxt = head[32] ? DRAIN : SPACE;
      SPACE: if (space_done && !empty) state_nxt = ISSUE;
      DRAIN: if (cnt == C_LAST) state_nxt = OUT;
      OUT:   if (out_ready) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt < C_LAST) begin
        cnt <= cnt + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum  <= '0;
      out_inf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (state == DRAIN && cnt == C_LAST) begin
      out_sum  <= acc_result;
      out_inf  <= acc_inf;
      out_zero <= acc_zero;
    end
  end

  assign acc_clr   = (state == CLEAR);
  assign acc_in    = (state == ISSUE) ? head[31:0] : 32'd0;
  assign acc_start = (state == PRIME) | (state == ISSUE) |
                     (state == SPACE) | (state == DRAIN);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

endmodule
